// File: rtl/cr_prefix_tlv_strip.sv
// cr_prefix_tlv_strip
//   Inbound TLV filter. It strips PHD/PFD prefix TLVs out of the stream and
//   checks their framing. Every other TLV is forwarded unchanged. For each
//   received prefix it writes one 9-bit {err, payload} record, and each good
//   record also pulses prefix_stat_events[num].
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     ib_tlv_empty/ib_tlv upstream FIFO head
//     ib_tlv_rd           upstream pop (combinational)
//     ob_full/ob_afull    downstream FIFO status
//     ob_tlv_wr/ob_tlv    forwarded word (registered, 1-cycle latency)
//     pr_full             prefix-record FIFO full
//     pr_wr/pr_data       prefix record (registered pulse)
//     prefix_stat_events  per-prefix-number good-record pulse

`ifndef CR_PREFIX_N_PHD_WORDS
`define CR_PREFIX_N_PHD_WORDS 4
`endif
`ifndef CR_PREFIX_N_PFD_WORDS
`define CR_PREFIX_N_PFD_WORDS 8
`endif

package cr_prefix_tlv_pkg;
  localparam logic [7:0] TLV_RQST = 8'd0;
  localparam logic [7:0] TLV_CMD  = 8'd1;
  localparam logic [7:0] TLV_FRMD = 8'd2;
  localparam logic [7:0] TLV_DATA = 8'd3;
  localparam logic [7:0] TLV_PHD  = 8'd4;
  localparam logic [7:0] TLV_PFD  = 8'd5;
  localparam logic [7:0] TLV_FTR  = 8'd6;

  // Header-word fields: tdata[63:56] type, [55:48] resv0, [7:0] tlv_len
  localparam int TLV_RESV0_LSB = 48;
  localparam int TLV_LEN_LSB   = 0;

  typedef struct packed {
    logic [7:0]  typen;
    logic        sot;
    logic        eot;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } tlvp_if_bus_t;
endpackage

module cr_prefix_tlv_strip
  import cr_prefix_tlv_pkg::*;
#(
  parameter int         N_PHD_WORDS = `CR_PREFIX_N_PHD_WORDS,
  parameter int         N_PFD_WORDS = `CR_PREFIX_N_PFD_WORDS,
  parameter logic [7:0] ERR_CODE    = 8'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ib_tlv_empty,
  input  tlvp_if_bus_t  ib_tlv,
  output logic          ib_tlv_rd,
  input  logic          ob_full,
  input  logic          ob_afull,
  output logic          ob_tlv_wr,
  output tlvp_if_bus_t  ob_tlv,
  input  logic          pr_full,
  output logic          pr_wr,
  output logic [8:0]    pr_data,
  output logic [63:0]   prefix_stat_events
);

  localparam logic [7:0] PHD_N   = 8'(N_PHD_WORDS);
  localparam logic [7:0] PFD_N   = 8'(N_PFD_WORDS);
  localparam logic [7:0] PHD_LEN = 8'((N_PHD_WORDS * 8) / 4);

  typedef enum logic [1:0] {ST_IDLE, ST_PHD, ST_PFD, ST_WAIT_PFD} state_e;

  state_e     state, state_n;
  logic [7:0] wcnt, wcnt_n;
  logic       have_phd, have_phd_n;
  logic [5:0] phd_num, phd_num_n;
  logic [5:0] pfd_num, pfd_num_n;
  logic       bad, bad_n;

  logic       stall;
  logic       fwd, rec_err, rec_good;
  logic       idle_word, first, in_tlv, cur_phd, pfd_ok;
  logic [7:0] lim;
  logic       phd_sot, pfd_sot;
  logic [5:0] hdr_num;
  logic [7:0] hdr_len;

  // ob_afull only matters while a write is landing this cycle
  assign stall     = ob_full | (ob_afull & ob_tlv_wr) | pr_full;
  assign ib_tlv_rd = ~ib_tlv_empty & ~stall;

  assign phd_sot = ib_tlv.sot & (ib_tlv.typen == TLV_PHD);
  assign pfd_sot = ib_tlv.sot & (ib_tlv.typen == TLV_PFD);
  assign hdr_num = ib_tlv.tdata[TLV_RESV0_LSB +: 6];
  assign hdr_len = ib_tlv.tdata[TLV_LEN_LSB +: 8];

  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    have_phd_n = have_phd;
    phd_num_n  = phd_num;
    pfd_num_n  = pfd_num;
    bad_n      = bad;
    fwd        = 1'b0;
    rec_err    = 1'b0;
    rec_good   = 1'b0;
    idle_word  = 1'b0;
    first      = 1'b0;
    in_tlv     = 1'b0;
    cur_phd    = 1'b0;
    pfd_ok     = 1'b0;
    lim        = PFD_N;

    if (ib_tlv_rd) begin
      case (state)
        ST_IDLE: idle_word = 1'b1;
        ST_WAIT_PFD: begin
          if (pfd_sot) begin
            state_n = ST_PFD;
            first   = 1'b1;
          end else begin
            // missing PFD: report it, then treat the word as fresh traffic
            rec_err    = 1'b1;
            have_phd_n = 1'b0;
            idle_word  = 1'b1;
          end
        end
        default: begin // ST_PHD, ST_PFD
          if (ib_tlv.sot) begin
            // truncated prefix; the new word starts over in the same cycle
            rec_err    = 1'b1;
            have_phd_n = 1'b0;
            idle_word  = 1'b1;
          end else begin
            in_tlv = 1'b1;
          end
        end
      endcase

      if (idle_word) begin
        state_n = ST_IDLE;
        if (phd_sot) begin
          state_n = ST_PHD;
          first   = 1'b1;
        end else if (pfd_sot) begin
          state_n    = ST_PFD;
          have_phd_n = 1'b0;
          first      = 1'b1;
        end else begin
          fwd = 1'b1;
        end
      end

      cur_phd = (state_n == ST_PHD);
      lim     = cur_phd ? PHD_N : PFD_N;

      if (first) begin
        wcnt_n = 8'd1;
        bad_n  = cur_phd && (hdr_len != PHD_LEN);
        if (cur_phd) phd_num_n = hdr_num;
        else         pfd_num_n = hdr_num;
      end else if (in_tlv) begin
        wcnt_n = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
        if (wcnt_n > lim) bad_n = 1'b1;
      end

      if ((first || in_tlv) && ib_tlv.eot) begin
        if (cur_phd) begin
          if (wcnt_n == PHD_N && !bad_n) begin
            state_n    = ST_WAIT_PFD;
            have_phd_n = 1'b1;
          end else begin
            state_n    = ST_IDLE;
            have_phd_n = 1'b0;
            rec_err    = 1'b1;
          end
        end else begin
          pfd_ok = (wcnt_n == PFD_N) && !bad_n &&
                   (!have_phd_n || (phd_num == pfd_num_n));
          // a truncation record from this same word takes precedence
          if (pfd_ok && !rec_err) rec_good = 1'b1;
          else                    rec_err  = 1'b1;
          state_n    = ST_IDLE;
          have_phd_n = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      wcnt               <= '0;
      have_phd           <= 1'b0;
      phd_num            <= '0;
      pfd_num            <= '0;
      bad                <= 1'b0;
      ob_tlv_wr          <= 1'b0;
      ob_tlv             <= '0;
      pr_wr              <= 1'b0;
      pr_data            <= '0;
      prefix_stat_events <= '0;
    end else begin
      state              <= state_n;
      wcnt               <= wcnt_n;
      have_phd           <= have_phd_n;
      phd_num            <= phd_num_n;
      pfd_num            <= pfd_num_n;
      bad                <= bad_n;
      ob_tlv_wr          <= fwd;
      if (fwd) ob_tlv    <= ib_tlv;
      pr_wr              <= rec_err | rec_good;
      if (rec_err | rec_good)
        pr_data <= rec_err ? {1'b1, ERR_CODE} : {3'b000, pfd_num_n};
      prefix_stat_events <= rec_good ? (64'd1 << pfd_num_n) : 64'd0;
    end
  end

endmodule

// File: doc/cr_prefix_tlv_strip.md
# cr_prefix_tlv_strip

Receive-side counterpart of the prefix outbound inserter. It sits on the engine's inbound TLV path, after the user-frame FIFO. It removes the PHD/PFD prefix TLVs that follow a framed user-data TLV, checks their framing, and forwards every other TLV unchanged. It also emits one 9-bit prefix record per received prefix, in the same `{err, payload}` format the inserter consumes from its prefix FIFO, together with the per-prefix-number stat pulse.

## Interface
- N_PHD_WORDS, default `CR_PREFIX_N_PHD_WORDS: number of words in a PHD TLV.
- N_PFD_WORDS, default `CR_PREFIX_N_PFD_WORDS: number of words in a PFD TLV.
- ERR_CODE, default 8'd1: error code placed in the record when prefix framing is bad.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ib_tlv_empty  in  1  upstream TLV FIFO empty.
- ib_tlv  in  tlvp_if_bus_t  upstream TLV word (typen, sot, eot, tdata, ...).
- ib_tlv_rd  out  1  pop of the upstream FIFO; combinational.
- ob_full  in  1  downstream FIFO full.
- ob_afull  in  1  downstream FIFO almost full.
- ob_tlv_wr  out  1  downstream write strobe; registered.
- ob_tlv  out  tlvp_if_bus_t  forwarded TLV word; registered.
- pr_full  in  1  prefix-record FIFO full.
- pr_wr  out  1  prefix-record write; registered, single-cycle pulse.
- pr_data  out  9  record: `{1'b0, 2'b0, num[5:0]}` when good, `{1'b1, ERR_CODE}` when bad.
- prefix_stat_events  out  64  one-cycle pulse on bit `num` for each good record.

## Operation
- stall = ob_full | (ob_afull & ob_tlv_wr) | pr_full.
- ib_tlv_rd = ~ib_tlv_empty & ~stall.
- Words are processed only when ib_tlv_rd = 1.
- States:
  - IDLE: passthrough.
  - PHD: inside a PHD TLV.
  - PFD: inside a PFD TLV.
  - WAIT_PFD: a PHD has completed and a PFD is expected next.
- Word counter wcnt (8 bit) counts words of the current PHD/PFD, starting at 1 on sot.
- Register have_phd, phd_num[5:0].
- IDLE:
  - A typen=PHD word with sot goes to PHD and captures phd_num = tdata.resv0[5:0].
  - A typen=PFD word with sot goes to PFD with have_phd = 0.
  - Any other word is forwarded: next cycle ob_tlv = word, ob_tlv_wr = 1.
- PHD/PFD words are never forwarded (ob_tlv_wr = 0 for them).
- PHD word 1 check: tlv_len must equal (N_PHD_WORDS*8)/4; otherwise the TLV is marked bad.
- PHD eot:
  - If wcnt == N_PHD_WORDS, go to WAIT_PFD with have_phd = 1.
  - Otherwise emit an error record and go to IDLE.
- WAIT_PFD:
  - A PFD with sot goes to PFD.
  - Any other word emits an error record, is then handled as in IDLE, and the state returns to IDLE.
- PFD word 1 capture: pfd_num = tdata.resv0[5:0].
- PFD eot with wcnt == N_PFD_WORDS, no bad mark, and (!have_phd or phd_num == pfd_num):
  - Emit a good record with num = pfd_num and pulse prefix_stat_events[pfd_num].
  - Otherwise emit an error record.
  - In either case go to IDLE and clear have_phd.
- Truncation: a sot word arriving in PHD/PFD before eot emits an error record. The new word is then handled as in IDLE, in the same cycle.
- Overrun: if wcnt would exceed N_*_WORDS, the TLV is marked bad and the remaining words are discarded until eot.
- At most one record per input word, so the pr_full stall is sufficient.
- The error record suppresses the stat pulse.
- wcnt saturates at 8'hFF.

## Timing
- Reset values:
  - ob_tlv_wr = 0, ob_tlv = 0.
  - pr_wr = 0, pr_data = 0.
  - prefix_stat_events = 0.
  - state = IDLE, wcnt = 0, have_phd = 0.
- Latency: input word to ob_tlv_wr/ob_tlv is 1 cycle; input eot to pr_wr is 1 cycle.
- Throughput is one word per cycle when not stalled.
- ob_tlv_wr deasserts in any cycle with no forwarded read. ob_tlv holds its last value.
- When stall asserts mid-TLV, state and wcnt are frozen.
- A reset asserted mid-prefix drops the partial prefix and emits no record.

## Test plan
- Parameters N_PHD_WORDS=4, N_PFD_WORDS=8. Sequence CMD(3) FRMD(5, sot..eot), then PHD(4, resv0=6'd9, tlv_len=8), then PFD(8, resv0=9), then FTR(1). Required:
  - 9 writes downstream (CMD, FRMD, FTR), in order.
  - One pr_wr with pr_data = 9'h009.
  - prefix_stat_events[9] pulses once.
- PFD-only (8 words, resv0=6'd63) after FRMD → pr_data = 9'h03F, bit 63 pulses, PFD not forwarded.
- PFD with eot on word 7 → pr_data = 9'h101 (ERR_CODE=1), no stat pulse. The following FTR is forwarded.
- PHD (resv0=5) followed by PFD (resv0=6) → error record 9'h101.
- PHD followed directly by FTR → error record, then FTR forwarded 1 cycle later.
- Hold ob_full=1 for 10 cycles mid-PFD → ib_tlv_rd=0 throughout and no words lost. Once ob_full falls, the record matches the unstalled run.
- pr_full=1 → ib_tlv_rd=0.
- Pulse rst_n low while in state PFD → pr_wr stays 0, and a subsequent clean prefix produces a normal record.
